// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the pipeline hazard controller: icodes, status codes,
// register sentinel and the CPU run-state encoding.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOV  = 4'h2;
   localparam logic [3:0] I_IRMOV  = 4'h3;
   localparam logic [3:0] I_RMMOV  = 4'h4;
   localparam logic [3:0] I_MRMOV  = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSH   = 4'hA;
   localparam logic [3:0] I_POP    = 4'hB;

   localparam logic [3:0] RNONE    = 4'hF;

   localparam logic [2:0] S_AOK    = 3'd1;
   localparam logic [2:0] S_HLT    = 3'd2;
   localparam logic [2:0] S_ADR    = 3'd3;
   localparam logic [2:0] S_INS    = 3'd4;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALTED   = 2'd2,
      ST_FAULT    = 2'd3
   } cpu_state_t;

   function automatic logic is_exc(input logic [2:0] s);
      return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
   endfunction

   // Instructions that touch data memory from the M stage.
   function automatic logic is_mem_op(input logic [3:0] ic);
      return ic inside {I_RMMOV, I_MRMOV, I_CALL, I_RET, I_PUSH, I_POP};
   endfunction

endpackage

// File: rtl/y86_perf_counters.sv
// Free-running wrap-around performance counters for stalls, bubbles and mispredicts.
// Only instantiated when PERF_CNT_EN is defined.
module y86_perf_counters #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_inc,
   input  logic             bubble_inc,
   input  logic             mispred_inc,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt   <= '0;
         bubble_cnt  <= '0;
         mispred_cnt <= '0;
      end else begin
         if (stall_inc)   stall_cnt   <= stall_cnt   + CNT_W'(1);
         if (bubble_inc)  bubble_cnt  <= bubble_cnt  + CNT_W'(1);
         if (mispred_inc) mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline hazard controller: per-stage stall/bubble, run-state FSM and dmem handshake.
// Define PERF_CNT_EN to add the stall/bubble/mispredict performance counters.
module pipe_hazard_ctrl
   import y86_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
`ifdef PERF_CNT_EN
   , parameter int CNT_W = 32
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] D_icode,
   input  logic [3:0] d_srcA,
   input  logic [3:0] d_srcB,
   input  logic [3:0] E_icode,
   input  logic [3:0] E_dstM,
   input  logic       e_Cnd,
   input  logic [3:0] M_icode,
   input  logic [2:0] m_stat,
   input  logic [2:0] W_stat,
   input  logic       dmem_ack,
   output logic       F_stall,
   output logic       D_stall,
   output logic       M_stall,
   output logic       W_stall,
   output logic       D_bubble,
   output logic       E_bubble,
   output logic       M_bubble,
   output logic       W_bubble,
   output logic       set_cc,
   output logic       dmem_req,
   output logic [1:0] cpu_state,
   output logic [2:0] cpu_stat
`ifdef PERF_CNT_EN
   , output logic [CNT_W-1:0] stall_cnt
   , output logic [CNT_W-1:0] bubble_cnt
   , output logic [CNT_W-1:0] mispred_cnt
`endif
);

   localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

   cpu_state_t       state, state_nxt;
   logic [TMR_W-1:0] timer, timer_nxt;
   logic [2:0]       stat_nxt;

   logic load_use, ret_pend, mispred, m_exc, w_exc;
   logic live, mem_ok, wait_now;

   assign load_use = ((E_icode == I_MRMOV) || (E_icode == I_POP)) && (E_dstM != RNONE) &&
                     ((E_dstM == d_srcA) || (E_dstM == d_srcB));
   assign ret_pend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
   assign mispred  = (E_icode == I_JXX) && !e_Cnd;
   assign m_exc    = is_exc(m_stat);
   assign w_exc    = is_exc(W_stat);

   assign live     = (state == ST_RUN) || (state == ST_MEM_WAIT);
   assign mem_ok   = live && is_mem_op(M_icode) && (m_stat == S_AOK) && (W_stat == S_AOK);
   // A request without ack holds the pipe this very cycle, even from RUN.
   assign wait_now = mem_ok && !dmem_ack;

   always_comb begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      M_stall  = 1'b0;
      W_stall  = 1'b0;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      M_bubble = 1'b0;
      W_bubble = 1'b0;
      set_cc   = 1'b0;
      dmem_req = 1'b0;
      if (reset) begin
         D_bubble = 1'b1;
         E_bubble = 1'b1;
         M_bubble = 1'b1;
         W_bubble = 1'b1;
      end else if (!live) begin
         F_stall  = 1'b1;
         D_stall  = 1'b1;
         M_stall  = 1'b1;
         W_stall  = 1'b1;
         E_bubble = 1'b1;
      end else begin
         dmem_req = mem_ok;
         if (wait_now) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            M_stall  = 1'b1;
            W_bubble = 1'b1;
         end else begin
            F_stall  = load_use || ret_pend;
            D_stall  = load_use;
            D_bubble = mispred || (ret_pend && !load_use);
            E_bubble = mispred || load_use;
            M_bubble = m_exc || w_exc;
            W_stall  = w_exc;
            set_cc   = (E_icode == I_OPQ) && !m_exc && !w_exc;
         end
      end
   end

   // W-stage exceptions outrank the memory wait; ack outranks the timeout.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      stat_nxt  = cpu_stat;
      if (live) begin
         if (w_exc) begin
            state_nxt = (W_stat == S_HLT) ? ST_HALTED : ST_FAULT;
            stat_nxt  = W_stat;
            timer_nxt = '0;
         end else if (!wait_now) begin
            state_nxt = ST_RUN;
            timer_nxt = '0;
         end else if ((state == ST_MEM_WAIT) && (timer == TMR_W'(MEM_TIMEOUT))) begin
            state_nxt = ST_FAULT;
            stat_nxt  = S_ADR;
            timer_nxt = '0;
         end else begin
            state_nxt = ST_MEM_WAIT;
            timer_nxt = (state == ST_RUN) ? TMR_W'(1) : timer + TMR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_RUN;
         timer    <= '0;
         cpu_stat <= S_AOK;
      end else begin
         state    <= state_nxt;
         timer    <= timer_nxt;
         cpu_stat <= stat_nxt;
      end
   end

   assign cpu_state = state;

`ifdef PERF_CNT_EN
   y86_perf_counters #(.CNT_W(CNT_W)) u_perf (
      .clk         (clk),
      .reset       (reset),
      .stall_inc   (F_stall),
      .bubble_inc  (!reset && (D_bubble || E_bubble || M_bubble || W_bubble)),
      .mispred_inc (!reset && mispred && (state == ST_RUN)),
      .stall_cnt   (stall_cnt),
      .bubble_cnt  (bubble_cnt),
      .mispred_cnt (mispred_cnt)
   );
`endif

   a_no_stall_and_bubble: assert property (@(posedge clk) disable iff (reset)
      !(D_stall && D_bubble) && !(M_stall && M_bubble) && !(W_stall && W_bubble));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario bench for pipe_hazard_ctrl (MEM_TIMEOUT=4); expected control words are queued
// as each stimulus row is driven and compared when the outputs settle.
module tb_pipe_hazard_ctrl;
   import y86_pkg::*;

   logic       clk, reset;
   logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
   logic       e_Cnd, dmem_ack;
   logic [2:0] m_stat, W_stat;
   logic       F_stall, D_stall, M_stall, W_stall;
   logic       D_bubble, E_bubble, M_bubble, W_bubble;
   logic       set_cc, dmem_req;
   logic [1:0] cpu_state;
   logic [2:0] cpu_stat;
`ifdef PERF_CNT_EN
   logic [31:0] stall_cnt, bubble_cnt, mispred_cnt;
`endif

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
      .m_stat(m_stat), .W_stat(W_stat), .dmem_ack(dmem_ack),
      .F_stall(F_stall), .D_stall(D_stall), .M_stall(M_stall), .W_stall(W_stall),
      .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_bubble(W_bubble),
      .set_cc(set_cc), .dmem_req(dmem_req), .cpu_state(cpu_state), .cpu_stat(cpu_stat)
`ifdef PERF_CNT_EN
      , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .mispred_cnt(mispred_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control word order: F_stall D_stall M_stall W_stall D_bub E_bub M_bub W_bub set_cc dmem_req
   localparam logic [9:0] C_FS = 10'h200, C_DS = 10'h100, C_MS = 10'h080, C_WS = 10'h040;
   localparam logic [9:0] C_DB = 10'h020, C_EB = 10'h010, C_MB = 10'h008, C_WB = 10'h004;
   localparam logic [9:0] C_CC = 10'h002, C_RQ = 10'h001;
   localparam logic [9:0] C_BUB  = C_DB | C_EB | C_MB | C_WB;
   localparam logic [9:0] C_HOLD = C_FS | C_DS | C_MS | C_WS | C_EB;
   localparam logic [9:0] C_WAIT = C_FS | C_DS | C_MS | C_WB | C_RQ;

   typedef struct packed {
      logic       r;
      logic [3:0] dic, sa, sb, eic, edm;
      logic       cnd;
      logic [3:0] mic;
      logic [2:0] ms, ws;
      logic       ack;
   } stim_t;

   typedef struct packed {
      logic [9:0] ctl;
      logic [1:0] st;
      logic [2:0] stat;
   } obs_t;

   stim_t pend_s[$];
   obs_t  pend_x[$];
   obs_t  sbq[$];
   int    n_chk  = 0;
   int    n_fail = 0;

   function automatic stim_t mk(input logic r = 1'b0, input logic [3:0] dic = I_NOP,
                                input logic [3:0] sa = RNONE, input logic [3:0] sb = RNONE,
                                input logic [3:0] eic = I_NOP, input logic [3:0] edm = RNONE,
                                input logic cnd = 1'b1, input logic [3:0] mic = I_NOP,
                                input logic [2:0] ms = S_AOK, input logic [2:0] ws = S_AOK,
                                input logic ack = 1'b0);
      stim_t s;
      s = {r, dic, sa, sb, eic, edm, cnd, mic, ms, ws, ack};
      return s;
   endfunction

   task automatic add(input stim_t s, input logic [9:0] c, input logic [1:0] st, input logic [2:0] stat);
      obs_t o;
      o = {c, st, stat};
      pend_s.push_back(s);
      pend_x.push_back(o);
   endtask

   task automatic drive(input stim_t s);
      reset = s.r; D_icode = s.dic; d_srcA = s.sa; d_srcB = s.sb; E_icode = s.eic;
      E_dstM = s.edm; e_Cnd = s.cnd; M_icode = s.mic; m_stat = s.ms; W_stat = s.ws;
      dmem_ack = s.ack;
   endtask

   function automatic obs_t observe();
      obs_t o;
      o = {F_stall, D_stall, M_stall, W_stall, D_bubble, E_bubble, M_bubble, W_bubble,
           set_cc, dmem_req, cpu_state, cpu_stat};
      return o;
   endfunction

   task automatic test_reset();
      obs_t got, want;
      add(mk(.r(1'b1), .mic(I_RMMOV), .eic(I_OPQ), .dic(I_RET)), C_BUB, ST_RUN, S_AOK);
      add(mk(), 10'h000, ST_RUN, S_AOK);
      for (int i = 0; pend_s.size() > 0; i++) begin
         drive(pend_s.pop_front()); sbq.push_back(pend_x.pop_front());
         @(negedge clk);
         got = observe(); want = sbq.pop_front(); n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL reset[%0d]: got ctl=%b st=%0d stat=%0d, want ctl=%b st=%0d stat=%0d",
                     i, got.ctl, got.st, got.stat, want.ctl, want.st, want.stat);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      obs_t got, want;
      add(mk(.eic(I_MRMOV), .edm(4'd3), .sa(4'd3)), C_FS | C_DS | C_EB, ST_RUN, S_AOK);
      add(mk(.eic(I_POP), .edm(4'd5), .sb(4'd5)), C_FS | C_DS | C_EB, ST_RUN, S_AOK);
      add(mk(.eic(I_MRMOV), .edm(RNONE), .sa(RNONE), .sb(RNONE)), 10'h000, ST_RUN, S_AOK);
      add(mk(.eic(I_MRMOV), .edm(4'd3), .sa(4'd4), .sb(4'd5)), 10'h000, ST_RUN, S_AOK);
      add(mk(.dic(I_RET), .eic(I_MRMOV), .edm(4'd3), .sa(4'd3)), C_FS | C_DS | C_EB, ST_RUN, S_AOK);
      add(mk(), 10'h000, ST_RUN, S_AOK);
      for (int i = 0; pend_s.size() > 0; i++) begin
         drive(pend_s.pop_front()); sbq.push_back(pend_x.pop_front());
         @(negedge clk);
         got = observe(); want = sbq.pop_front(); n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL load_use[%0d]: got ctl=%b st=%0d stat=%0d, want ctl=%b st=%0d stat=%0d",
                     i, got.ctl, got.st, got.stat, want.ctl, want.st, want.stat);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mispred_cc();
      obs_t got, want;
      add(mk(.eic(I_JXX), .cnd(1'b0)), C_DB | C_EB, ST_RUN, S_AOK);
      add(mk(.eic(I_JXX), .cnd(1'b1)), 10'h000, ST_RUN, S_AOK);
      add(mk(.eic(I_OPQ)), C_CC, ST_RUN, S_AOK);
      add(mk(.eic(I_OPQ), .ms(S_ADR)), C_MB, ST_RUN, S_AOK);
      for (int i = 0; pend_s.size() > 0; i++) begin
         drive(pend_s.pop_front()); sbq.push_back(pend_x.pop_front());
         @(negedge clk);
         got = observe(); want = sbq.pop_front(); n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL mispred_cc[%0d]: got ctl=%b st=%0d stat=%0d, want ctl=%b st=%0d stat=%0d",
                     i, got.ctl, got.st, got.stat, want.ctl, want.st, want.stat);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_ret();
      obs_t got, want;
      add(mk(.dic(I_RET)), C_FS | C_DB, ST_RUN, S_AOK);
      add(mk(.eic(I_RET)), C_FS | C_DB, ST_RUN, S_AOK);
      add(mk(.mic(I_RET), .ack(1'b1)), C_FS | C_DB | C_RQ, ST_RUN, S_AOK);
      add(mk(), 10'h000, ST_RUN, S_AOK);
      for (int i = 0; pend_s.size() > 0; i++) begin
         drive(pend_s.pop_front()); sbq.push_back(pend_x.pop_front());
         @(negedge clk);
         got = observe(); want = sbq.pop_front(); n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL ret[%0d]: got ctl=%b st=%0d stat=%0d, want ctl=%b st=%0d stat=%0d",
                     i, got.ctl, got.st, got.stat, want.ctl, want.st, want.stat);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_wait();
      obs_t got, want;
      add(mk(.mic(I_RMMOV), .eic(I_OPQ)), C_WAIT, ST_RUN, S_AOK);
      add(mk(.mic(I_RMMOV), .eic(I_OPQ)), C_WAIT, ST_MEM_WAIT, S_AOK);
      add(mk(.mic(I_RMMOV), .eic(I_OPQ)), C_WAIT, ST_MEM_WAIT, S_AOK);
      add(mk(.mic(I_RMMOV), .eic(I_OPQ), .ack(1'b1)), C_CC | C_RQ, ST_MEM_WAIT, S_AOK);
      add(mk(), 10'h000, ST_RUN, S_AOK);
      for (int i = 0; pend_s.size() > 0; i++) begin
         drive(pend_s.pop_front()); sbq.push_back(pend_x.pop_front());
         @(negedge clk);
         got = observe(); want = sbq.pop_front(); n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL mem_wait[%0d]: got ctl=%b st=%0d stat=%0d, want ctl=%b st=%0d stat=%0d",
                     i, got.ctl, got.st, got.stat, want.ctl, want.st, want.stat);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_ack_at_timeout();
      obs_t got, want;
      add(mk(.mic(I_MRMOV)), C_WAIT, ST_RUN, S_AOK);
      for (int k = 0; k < 3; k++) add(mk(.mic(I_MRMOV)), C_WAIT, ST_MEM_WAIT, S_AOK);
      add(mk(.mic(I_MRMOV), .ack(1'b1)), C_RQ, ST_MEM_WAIT, S_AOK);
      add(mk(), 10'h000, ST_RUN, S_AOK);
      for (int i = 0; pend_s.size() > 0; i++) begin
         drive(pend_s.pop_front()); sbq.push_back(pend_x.pop_front());
         @(negedge clk);
         got = observe(); want = sbq.pop_front(); n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL ack_at_timeout[%0d]: got ctl=%b st=%0d stat=%0d, want ctl=%b st=%0d stat=%0d",
                     i, got.ctl, got.st, got.stat, want.ctl, want.st, want.stat);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout();
      obs_t got, want;
      add(mk(.mic(I_MRMOV)), C_WAIT, ST_RUN, S_AOK);
      for (int k = 0; k < 4; k++) add(mk(.mic(I_MRMOV)), C_WAIT, ST_MEM_WAIT, S_AOK);
      add(mk(.mic(I_MRMOV), .ack(1'b1)), C_HOLD, ST_FAULT, S_ADR);
      add(mk(.r(1'b1)), C_BUB, ST_FAULT, S_ADR);
      add(mk(.r(1'b1)), C_BUB, ST_RUN, S_AOK);
      add(mk(), 10'h000, ST_RUN, S_AOK);
      for (int i = 0; pend_s.size() > 0; i++) begin
         drive(pend_s.pop_front()); sbq.push_back(pend_x.pop_front());
         @(negedge clk);
         got = observe(); want = sbq.pop_front(); n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL timeout[%0d]: got ctl=%b st=%0d stat=%0d, want ctl=%b st=%0d stat=%0d",
                     i, got.ctl, got.st, got.stat, want.ctl, want.st, want.stat);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_halt();
      obs_t got, want;
      add(mk(.ws(S_HLT), .eic(I_OPQ)), C_WS | C_MB, ST_RUN, S_AOK);
      add(mk(.ws(S_HLT)), C_HOLD, ST_HALTED, S_HLT);
      add(mk(.mic(I_RMMOV)), C_HOLD, ST_HALTED, S_HLT);
      add(mk(.r(1'b1)), C_BUB, ST_HALTED, S_HLT);
      add(mk(.r(1'b1)), C_BUB, ST_RUN, S_AOK);
      add(mk(), 10'h000, ST_RUN, S_AOK);
      for (int i = 0; pend_s.size() > 0; i++) begin
         drive(pend_s.pop_front()); sbq.push_back(pend_x.pop_front());
         @(negedge clk);
         got = observe(); want = sbq.pop_front(); n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL halt[%0d]: got ctl=%b st=%0d stat=%0d, want ctl=%b st=%0d stat=%0d",
                     i, got.ctl, got.st, got.stat, want.ctl, want.st, want.stat);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_wait_exception();
      obs_t got, want;
      add(mk(.mic(I_RMMOV)), C_WAIT, ST_RUN, S_AOK);
      add(mk(.mic(I_RMMOV), .ws(S_INS)), C_WS | C_MB, ST_MEM_WAIT, S_AOK);
      add(mk(.mic(I_RMMOV)), C_HOLD, ST_FAULT, S_INS);
      add(mk(.r(1'b1)), C_BUB, ST_FAULT, S_INS);
      add(mk(.r(1'b1)), C_BUB, ST_RUN, S_AOK);
      add(mk(), 10'h000, ST_RUN, S_AOK);
      for (int i = 0; pend_s.size() > 0; i++) begin
         drive(pend_s.pop_front()); sbq.push_back(pend_x.pop_front());
         @(negedge clk);
         got = observe(); want = sbq.pop_front(); n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL wait_exception[%0d]: got ctl=%b st=%0d stat=%0d, want ctl=%b st=%0d stat=%0d",
                     i, got.ctl, got.st, got.stat, want.ctl, want.st, want.stat);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      obs_t got, want;
      add(mk(.eic(I_MRMOV), .edm(4'd2), .sb(4'd2)), C_FS | C_DS | C_EB, ST_RUN, S_AOK);
      add(mk(.eic(I_JXX), .cnd(1'b0)), C_DB | C_EB, ST_RUN, S_AOK);
      add(mk(.dic(I_RET), .mic(I_PUSH), .ack(1'b1)), C_FS | C_DB | C_RQ, ST_RUN, S_AOK);
      add(mk(.mic(I_CALL), .eic(I_OPQ), .ack(1'b1)), C_CC | C_RQ, ST_RUN, S_AOK);
      add(mk(), 10'h000, ST_RUN, S_AOK);
      for (int i = 0; pend_s.size() > 0; i++) begin
         drive(pend_s.pop_front()); sbq.push_back(pend_x.pop_front());
         @(negedge clk);
         got = observe(); want = sbq.pop_front(); n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL back_to_back[%0d]: got ctl=%b st=%0d stat=%0d, want ctl=%b st=%0d stat=%0d",
                     i, got.ctl, got.st, got.stat, want.ctl, want.st, want.stat);
         end
         @(posedge clk); #1;
      end
   endtask

`ifdef PERF_CNT_EN
   task automatic test_perf();
      logic [31:0] exp_q[$];
      drive(mk(.r(1'b1)));
      @(posedge clk); #1;
      drive(mk(.eic(I_JXX), .cnd(1'b0)));
      @(posedge clk); #1;
      drive(mk(.eic(I_MRMOV), .edm(4'd3), .sa(4'd3)));
      @(posedge clk); #1;
      drive(mk());
      exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd1);
      @(negedge clk);
      n_chk++;
      if (stall_cnt !== exp_q.pop_front()) begin
         n_fail++; $display("FAIL perf_stall_cnt: got %0d want 1", stall_cnt);
      end
      n_chk++;
      if (bubble_cnt !== exp_q.pop_front()) begin
         n_fail++; $display("FAIL perf_bubble_cnt: got %0d want 2", bubble_cnt);
      end
      n_chk++;
      if (mispred_cnt !== exp_q.pop_front()) begin
         n_fail++; $display("FAIL perf_mispred_cnt: got %0d want 1", mispred_cnt);
      end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(mk(.r(1'b1)));
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_load_use();
      test_mispred_cc();
      test_ret();
      test_mem_wait();
      test_ack_at_timeout();
      test_timeout();
      test_halt();
      test_wait_exception();
      test_back_to_back();
`ifdef PERF_CNT_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
